// File: rtl/flankengenerator_if.sv
// Bus bundle for the pulse-burst generator: burst request and parameters in,
// pulse train and status out.
interface flankengenerator_if #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
);
  logic             start;
  logic [CNT_W-1:0] n_pulses;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic             signal;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] counter;

  modport master (
    output start, n_pulses, high_len, low_len,
    input  signal, busy, done, counter
  );

  modport slave (
    input  start, n_pulses, high_len, low_len,
    output signal, busy, done, counter
  );
endinterface

// File: rtl/flankengenerator.sv
// Programmable pulse-burst generator: N pulses of H high / L low cycles,
// with a registered count of emitted rising edges.
module flankengenerator #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input logic             clk,
  input logic             rst,
  flankengenerator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_lat, n_lat_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [LEN_W-1:0] h_lat, h_lat_nxt;
  logic [LEN_W-1:0] l_lat, l_lat_nxt;
  logic [LEN_W-1:0] phase, phase_nxt;
  logic             signal_q, signal_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [LEN_W-1:0] h_in, l_in;

  // Zero-length phases are promoted to one cycle so every pulse is visible.
  assign h_in = (bus.high_len == '0) ? LEN_W'(1) : bus.high_len;
  assign l_in = (bus.low_len == '0) ? LEN_W'(1) : bus.low_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      n_lat    <= '0;
      counter  <= '0;
      h_lat    <= '0;
      l_lat    <= '0;
      phase    <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      n_lat    <= n_lat_nxt;
      counter  <= counter_nxt;
      h_lat    <= h_lat_nxt;
      l_lat    <= l_lat_nxt;
      phase    <= phase_nxt;
      signal_q <= signal_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  // phase holds the cycles remaining in the current phase minus one.
  always_comb begin
    state_nxt   = state;
    n_lat_nxt   = n_lat;
    counter_nxt = counter;
    h_lat_nxt   = h_lat;
    l_lat_nxt   = l_lat;
    phase_nxt   = phase;
    signal_nxt  = signal_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.n_pulses != '0) begin
            n_lat_nxt   = bus.n_pulses;
            h_lat_nxt   = h_in;
            l_lat_nxt   = l_in;
            phase_nxt   = h_in - LEN_W'(1);
            state_nxt   = HIGH;
            signal_nxt  = 1'b1;
            busy_nxt    = 1'b1;
            counter_nxt = CNT_W'(1);
          end else begin
            done_nxt    = 1'b1;
            counter_nxt = '0;
          end
        end
      end
      HIGH: begin
        if (phase == '0) begin
          state_nxt  = LOW;
          signal_nxt = 1'b0;
          phase_nxt  = l_lat - LEN_W'(1);
        end else begin
          phase_nxt = phase - LEN_W'(1);
        end
      end
      LOW: begin
        if (phase == '0) begin
          if (counter < n_lat) begin
            state_nxt   = HIGH;
            signal_nxt  = 1'b1;
            counter_nxt = counter + CNT_W'(1);
            phase_nxt   = h_lat - LEN_W'(1);
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end else begin
          phase_nxt = phase - LEN_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        signal_nxt = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.signal  = signal_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.counter = counter;

endmodule

// File: tb/tb_flankengenerator.sv
// Table-driven bench for flankengenerator: burst vectors checked cycle by
// cycle, plus hand sequences for reset mid-burst and back-to-back START.
module tb_flankengenerator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passes = 0;
  int   checks = 0;

  flankengenerator_if #(.CNT_W(8), .LEN_W(8)) bus ();

  flankengenerator #(.CNT_W(8), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int h;
    int l;
    int exp_len;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input int n, input int h, input int l, input logic st);
    bus.n_pulses = 8'(n);
    bus.high_len = 8'(h);
    bus.low_len  = 8'(l);
    bus.start    = st;
  endtask

  initial begin
    int he, le, per;
    applyStimulus(0, 0, 0, 1'b0);

    // Hand-computed burst vectors: n, high_len, low_len, burst cycles, final count.
    vecs[0] = '{3, 2, 3, 15, 3};
    vecs[1] = '{0, 5, 5, 0, 0};
    vecs[2] = '{4, 0, 0, 8, 4};
    vecs[3] = '{1, 5, 1, 6, 1};
    vecs[4] = '{2, 3, 0, 8, 2};
    vecs[5] = '{255, 1, 1, 510, 255};

    #12;
    checkOutput("reset_signal", int'(bus.signal), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_counter", int'(bus.counter), 0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("idle_busy", int'(bus.busy), 0);

    for (int v = 0; v < 6; v++) begin
      he  = (vecs[v].h == 0) ? 1 : vecs[v].h;
      le  = (vecs[v].l == 0) ? 1 : vecs[v].l;
      per = he + le;
      applyStimulus(vecs[v].n, vecs[v].h, vecs[v].l, 1'b1);
      tick();
      // Scramble inputs after acceptance; only the latched copies may matter.
      applyStimulus(170, 7, 9, 1'b0);
      for (int j = 0; j < vecs[v].exp_len; j++) begin
        checkOutput($sformatf("v%0d_signal_c%0d", v, j), int'(bus.signal), ((j % per) < he) ? 1 : 0);
        checkOutput($sformatf("v%0d_counter_c%0d", v, j), int'(bus.counter), j / per + 1);
        checkOutput($sformatf("v%0d_busy_c%0d", v, j), int'(bus.busy), 1);
        checkOutput($sformatf("v%0d_done_c%0d", v, j), int'(bus.done), 0);
        if (j == 2) bus.start = 1'b1;
        if (j == 3) bus.start = 1'b0;
        tick();
      end
      checkOutput($sformatf("v%0d_end_done", v), int'(bus.done), 1);
      checkOutput($sformatf("v%0d_end_busy", v), int'(bus.busy), 0);
      checkOutput($sformatf("v%0d_end_signal", v), int'(bus.signal), 0);
      checkOutput($sformatf("v%0d_end_counter", v), int'(bus.counter), vecs[v].exp_cnt);
      tick();
      checkOutput($sformatf("v%0d_after_done", v), int'(bus.done), 0);
      checkOutput($sformatf("v%0d_hold_counter", v), int'(bus.counter), vecs[v].exp_cnt);
      checkOutput($sformatf("v%0d_after_busy", v), int'(bus.busy), 0);
    end

    // Reset asserted in the middle of a high phase.
    applyStimulus(3, 4, 1, 1'b1);
    tick();
    bus.start = 1'b0;
    tick();
    checkOutput("rst_pre_signal", int'(bus.signal), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_signal", int'(bus.signal), 0);
    checkOutput("rst_mid_busy", int'(bus.busy), 0);
    checkOutput("rst_mid_done", int'(bus.done), 0);
    checkOutput("rst_mid_counter", int'(bus.counter), 0);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      checkOutput("rst_idle_busy", int'(bus.busy), 0);
      checkOutput("rst_idle_signal", int'(bus.signal), 0);
      checkOutput("rst_idle_done", int'(bus.done), 0);
    end
    applyStimulus(1, 1, 1, 1'b1);
    tick();
    bus.start = 1'b0;
    checkOutput("rst_restart_signal", int'(bus.signal), 1);
    checkOutput("rst_restart_counter", int'(bus.counter), 1);
    tick();
    tick();
    checkOutput("rst_restart_done", int'(bus.done), 1);
    tick();

    // START held high: two-pulse burst, then a five-pulse burst after one idle cycle.
    applyStimulus(2, 1, 1, 1'b1);
    tick();
    bus.n_pulses = 8'd5;
    checkOutput("b2b_k0_signal", int'(bus.signal), 1);
    checkOutput("b2b_k0_counter", int'(bus.counter), 1);
    tick();
    checkOutput("b2b_k1_signal", int'(bus.signal), 0);
    tick();
    checkOutput("b2b_k2_signal", int'(bus.signal), 1);
    checkOutput("b2b_k2_counter", int'(bus.counter), 2);
    tick();
    checkOutput("b2b_k3_signal", int'(bus.signal), 0);
    tick();
    checkOutput("b2b_k4_done", int'(bus.done), 1);
    checkOutput("b2b_k4_busy", int'(bus.busy), 0);
    checkOutput("b2b_k4_counter", int'(bus.counter), 2);
    tick();
    bus.start = 1'b0;
    checkOutput("b2b_k5_signal", int'(bus.signal), 1);
    checkOutput("b2b_k5_busy", int'(bus.busy), 1);
    checkOutput("b2b_k5_counter", int'(bus.counter), 1);
    checkOutput("b2b_k5_done", int'(bus.done), 0);
    for (int j = 1; j < 10; j++) begin
      bus.start = (j % 3 == 0);
      tick();
      checkOutput($sformatf("b2b2_signal_c%0d", j), int'(bus.signal), (j % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("b2b2_counter_c%0d", j), int'(bus.counter), j / 2 + 1);
      checkOutput($sformatf("b2b2_done_c%0d", j), int'(bus.done), 0);
    end
    bus.start = 1'b0;
    tick();
    checkOutput("b2b2_end_done", int'(bus.done), 1);
    checkOutput("b2b2_end_counter", int'(bus.counter), 5);
    checkOutput("b2b2_end_busy", int'(bus.busy), 0);
    tick();
    checkOutput("b2b2_after_done", int'(bus.done), 0);
    checkOutput("b2b2_after_busy", int'(bus.busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
